// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, credit-limited imem requests, in-order response FIFO, redirect flush/discard.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding, count, discard, out_next;
  logic [CW:0]   credit;
  logic [AW-1:0] rd, wr, prd, pwr;
  logic [31:0]   f_instr [DEPTH];
  logic [31:0]   f_pc    [DEPTH];
  logic [31:0]   pcq     [DEPTH];
  logic          fire, resp, push, pop;
  always_comb begin
    credit      = {1'b0, outstanding} + {1'b0, count};
    o_imem_req  = i_rst_n && !i_redirect && credit < (CW+1)'(DEPTH);
    o_imem_addr = pc;
    fire        = o_imem_req && i_imem_gnt;
    resp        = i_imem_rvalid && outstanding != '0;
    push        = resp && discard == '0 && !i_redirect;
    o_valid     = count != '0 && !i_redirect;
    pop         = o_valid && !i_stall;
    out_next    = outstanding + CW'(fire) - CW'(resp);
    o_instr     = f_instr[rd];
    o_pc        = f_pc[rd];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc          <= RESET_PC & ~32'h3;
      outstanding <= '0;
      count       <= '0;
      discard     <= '0;
      rd          <= '0;
      wr          <= '0;
      prd         <= '0;
      pwr         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        f_instr[i] <= '0;
        f_pc[i]    <= '0;
        pcq[i]     <= '0;
      end
    end else begin
      outstanding <= out_next;
      if (fire) begin
        pcq[pwr] <= pc;
        pwr      <= pwr + 1'b1;
      end
      // the PC queue tracks every in-flight request, stale or not, so it is never flushed
      if (resp) prd <= prd + 1'b1;
      if (push) begin
        f_instr[wr] <= i_imem_rdata;
        f_pc[wr]    <= pcq[prd];
      end
      if (i_redirect) begin
        pc      <= i_redirect_pc & ~32'h3;
        discard <= out_next;
        rd      <= '0;
        wr      <= '0;
        count   <= '0;
      end else begin
        pc      <= fire ? pc + 32'd4 : pc;
        discard <= discard - CW'(resp && discard != '0);
        wr      <= wr + AW'(push);
        rd      <= rd + AW'(pop);
        count   <= count + CW'(push) - CW'(pop);
      end
    end
  end
  a_align:    assert property (@(posedge i_clk) disable iff (!i_rst_n) o_imem_addr[1:0] == 2'b00);
  a_credit:   assert property (@(posedge i_clk) disable iff (!i_rst_n) credit <= (CW+1)'(DEPTH));
  a_discard:  assert property (@(posedge i_clk) disable iff (!i_rst_n) discard <= outstanding);
  a_redirect: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(o_valid && i_redirect));
  a_protocol: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_imem_rvalid && outstanding == '0));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic checked each cycle against a queue-based model of the fetch stage.
module tb_fetch_stage;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req, gnt = 1'b0, rvalid = 1'b0, redirect = 1'b0, stall = 1'b0, valid;
  logic [31:0] addr, rdata = '0, redirect_pc = '0, instr, pc;
  int          total = 0, bad = 0, cyc = 0;
  typedef struct packed {logic [31:0] pc; logic stale;} ent_t;
  ent_t        inf[$];
  logic [63:0] fq[$];
  logic [31:0] mem_a[$];
  int          mem_t[$];
  logic [31:0] mpc;

  fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_stall(stall),
    .o_valid(valid), .o_instr(instr), .o_pc(pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", n, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    inf.delete(); fq.delete(); mem_a.delete(); mem_t.delete();
    mpc = RPC;
  endtask

  task automatic cycle(input logic g, input logic r, input logic [31:0] rp, input logic s, input logic rv_en);
    logic exp_req, exp_valid;
    ent_t e;
    @(negedge clk);
    gnt = g; redirect = r; redirect_pc = rp; stall = s;
    rvalid = rv_en && mem_a.size() > 0 && mem_t[0] < cyc;
    rdata  = rvalid ? data_of(mem_a[0]) : $urandom;
    #1;
    exp_req   = !r && (inf.size() + fq.size() < DEPTH);
    exp_valid = fq.size() > 0 && !r;
    chk("req", 32'(req), 32'(exp_req));
    chk("addr", addr, mpc);
    chk("valid", 32'(valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("pc", pc, fq[0][63:32]);
      chk("instr", instr, fq[0][31:0]);
    end
    if (req && g) begin
      mem_a.push_back(addr);
      mem_t.push_back(cyc);
    end
    if (rvalid) begin
      void'(mem_a.pop_front());
      void'(mem_t.pop_front());
      if (inf.size() > 0) begin
        e = inf.pop_front();
        if (!e.stale && !r) fq.push_back({e.pc, rdata});
      end
    end
    if (exp_valid && !s) void'(fq.pop_front());
    if (r) begin
      fq.delete();
      foreach (inf[i]) inf[i].stale = 1'b1;
      mpc = rp & ~32'h3;
    end else if (exp_req && g) begin
      inf.push_back('{pc: mpc, stale: 1'b0});
      mpc += 4;
    end
    cyc++;
  endtask

  task automatic rand_run(input int n, input int gp, input int rp, input int sp, input int dp);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(99) < gp, $urandom_range(99) < dp, $urandom, $urandom_range(99) < sp,
            $urandom_range(99) < rp);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 0, 1);
    chk("lit_req0", 32'(req), 32'h1);
    chk("lit_addr0", addr, 32'h0000_0100);
    cycle(1, 0, 0, 0, 1);
    chk("lit_valid1", 32'(valid), 32'h0);
    chk("lit_addr1", addr, 32'h0000_0104);
    cycle(1, 0, 0, 0, 1);
    chk("lit_valid2", 32'(valid), 32'h1);
    chk("lit_pc2", pc, 32'h0000_0100);
    chk("lit_instr2", instr, 32'h5A5A_0100);
    rand_run(20, 100, 100, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 1);
    rand_run(10, 100, 100, 0, 0);
    cycle(1, 1, 32'h0000_2003, 0, 1);
    cycle(1, 0, 0, 0, 1);
    chk("lit_redir_addr", addr, 32'h0000_2000);
    rand_run(10, 100, 100, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    rand_run(400, 75, 70, 25, 4);
    for (int i = 0; i < 40; i++) cycle(1, $urandom_range(99) < 20, $urandom, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1, 1);
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b0; redirect = 1'b0; stall = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_req", 32'(req), 32'h0);
    chk("async_pc", pc, 32'h0);
    chk("async_instr", instr, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 0, 1);
    chk("lit_restart_addr", addr, 32'h0000_0100);
    rand_run(300, 80, 80, 20, 3);
    rand_run(100, 100, 100, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
